vball_sprite_dma: RTL
=====================

// Module: vball_sprite_dma
// PURPOSE
//  CPU-side writer and vblank shadow-copy engine for the 256-byte sprite RAM.
//  The CPU reads and writes a working bank A at any time. On each vblank rising
//  edge an internal engine copies all of bank A into shadow bank B.
//  The sprite renderer reads bank B via sma/smd, so it sees a stable,
//  frame-coherent sprite list (4 bytes x 64: y, attr, id, x).
// PARAMETERS
//  AW  8  address width; each bank is 2**AW bytes
//  DW  8  data width
// PORTS
//  clk_sys    in   1   system clock; all logic on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  cpu_addr   in   AW  CPU address into bank A
//  cpu_din    in   DW  CPU write data
//  cpu_we     in   1   CPU write strobe, one byte per cycle while high
//  cpu_dout   out  DW  registered read of A[cpu_addr], 1-cycle latency
//  vblank     in   1   vertical blank level from video timing
//  sma        in   AW  renderer read address into bank B
//  smd        out  DW  registered read of B[sma], 1-cycle latency
//  busy       out  1   high while the copy engine is running
//  done       out  1   1-cycle pulse when the last byte is written to B
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State goes to IDLE. busy=0, done=0, cpu_dout=0, smd=0, copy index=0.
//   - Edge-detect register vbl_q=0.
//   - Bank contents are not cleared.
//  Edge detect: vbl_q<=vblank each cycle. Start condition = vblank & ~vbl_q.
//  FSM:
//   - IDLE: on start -> COPY, idx<=0, busy<=1 on the next edge.
//       Start while not IDLE is ignored (no restart, no queueing).
//   - COPY: 2-stage pipeline. Cycle k reads A[idx]. Cycle k+1 writes that byte
//       to B[idx-1]. idx increments each cycle; it stops advancing after 2**AW-1.
//       After the read of the last address -> FLUSH.
//   - FLUSH: write the final byte to B[2**AW-1]. done<=1, busy<=0 -> IDLE.
//  Copy duration: busy is high exactly 2**AW+1 cycles (257 at AW=8).
//   - done pulses on the cycle busy falls.
//   - The copy completes even if vblank falls mid-copy.
//  CPU port:
//   - Writes always land in A. Bank B is never CPU-writable.
//   - cpu_we and a read of the same address in one cycle: cpu_dout returns the
//       old byte (read-before-write).
//  Collision forwarding: if cpu_we=1 and cpu_addr equals the copy read address
//   in that cycle, the copy captures cpu_din, not the stale A byte.
//   - B and A then agree at that address.
//   - A CPU write to an address already copied goes to A only. It reaches B on
//       the next vblank.
//  Renderer port:
//   - smd = B[sma] registered, read-before-write when the copy writes the same
//       address that cycle.
//   - During COPY the renderer sees a mix of old and new bytes. This is legal:
//       the renderer is idle in vblank.
//  Widths: idx is AW+1 bits so the end condition needs no wrap compare. Address
//   arithmetic uses modulo 2**AW.
//  Reset mid-copy: the engine stops at once and B is left partially updated.
//   The next vblank edge performs a full copy and restores coherence.
// TESTING
//  1 Reset with rst_n=0 for 3 cycles -> busy=0, done=0, smd=0, cpu_dout=0;
//    no copy starts while vblank stays 0.
//  2 CPU writes A[i]=i^8'h5A for all 256 addresses, then vblank 0->1 ->
//    busy=1 for 257 cycles, one done pulse; a sweep of sma 0..255 gives
//    smd=sma^8'h5A, 1 cycle after each address.
//  3 After test 2, CPU writes A[8'h10]=8'h77 outside vblank -> smd at sma=8'h10
//    stays 8'h4A until the next done, then 8'h77; cpu_dout at 8'h10 reads 8'h77.
//  4 cpu_we with cpu_addr=8'h40, cpu_din=8'hAB in the exact cycle the copy reads
//    8'h40 -> after done, B[8'h40]=8'hAB and A[8'h40]=8'hAB.
//  5 Toggle vblank 1->0->1 at copy index 50 -> no restart; busy still lasts 257
//    cycles from the first edge; exactly one done pulse.
//  6 Pulse rst_n low at copy index 100 -> busy=0 within the same cycle (async);
//    the next vblank edge gives a full copy with B==A for all 256 addresses.

Source files
------------

// File: rtl/vball_sprite_dma.sv
`default_nettype none
// ============================================================================
// Module   : vball_sprite_dma
// Purpose  : Double-banked 256-byte sprite RAM with a vblank shadow copy.
//            The CPU reads and writes working bank A at any time. On every
//            vblank rising edge a copy engine moves all of bank A into shadow
//            bank B. The renderer reads bank B, so it always sees a complete,
//            frame-coherent sprite list.
// Ports    : clk_sys  - system clock, rising edge
//            rst_n    - asynchronous active-low reset
//            cpu_addr - CPU address into bank A
//            cpu_din  - CPU write data
//            cpu_we   - CPU write strobe, one byte per cycle
//            cpu_dout - registered A[cpu_addr], 1-cycle latency
//            vblank   - vertical blank level
//            sma      - renderer address into bank B
//            smd      - registered B[sma], 1-cycle latency
//            busy     - copy engine running
//            done     - 1-cycle pulse as busy falls
// Revision : 1.0 - initial release
// ============================================================================
module vball_sprite_dma #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_dout,
    input  logic          vblank,
    input  logic [AW-1:0] sma,
    output logic [DW-1:0] smd,
    output logic          busy,
    output logic          done
);

    localparam int          c_DEPTH = 1 << AW;
    // idx carries one extra bit so the last-address test is a plain compare.
    localparam logic [AW:0] c_LAST  = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] c_ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COPY  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    logic [DW-1:0] r_mem_a [0:c_DEPTH-1];
    logic [DW-1:0] r_mem_b [0:c_DEPTH-1];

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW:0]   r_idx;
    logic [AW:0]   w_idx_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_vbl_q;
    logic          w_start;

    logic [AW-1:0] w_copy_rd_addr;
    logic [DW-1:0] w_copy_byte;
    logic          r_pipe_vld;
    logic [AW-1:0] r_pipe_addr;
    logic [DW-1:0] r_pipe_data;

    logic [DW-1:0] r_cpu_dout;
    logic [DW-1:0] r_smd;

    assign w_start        = vblank & ~r_vbl_q;
    assign w_copy_rd_addr = r_idx[AW-1:0];

    // A CPU write hitting the address the engine reads this cycle would
    // otherwise only land in A after the read; forward it so B matches A.
    assign w_copy_byte = (cpu_we && (cpu_addr == w_copy_rd_addr)) ? cpu_din
                                                                  : r_mem_a[w_copy_rd_addr];

    // ------------------------------------------------------------------
    // Bank storage (not cleared by reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (cpu_we) begin
            r_mem_a[cpu_addr] <= cpu_din;
        end
    end

    // r_pipe_vld is reset asynchronously, so a reset mid-copy stops B writes
    // immediately and leaves B partially updated.
    always_ff @(posedge clk_sys) begin
        if (r_pipe_vld) begin
            r_mem_b[r_pipe_addr] <= r_pipe_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM state and registered datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_vbl_q     <= 1'b0;
            r_pipe_vld  <= 1'b0;
            r_pipe_addr <= '0;
            r_pipe_data <= '0;
            r_cpu_dout  <= '0;
            r_smd       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_vbl_q     <= vblank;
            // Read stage of the copy pipeline; the write stage lands in B
            // one cycle later, including the FLUSH cycle for the last byte.
            r_pipe_vld  <= (r_state == S_COPY);
            r_pipe_addr <= w_copy_rd_addr;
            r_pipe_data <= w_copy_byte;
            // Both read ports return the pre-write contents on a same-cycle
            // write to the same address.
            r_cpu_dout  <= r_mem_a[cpu_addr];
            r_smd       <= r_mem_b[sma];
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_COPY;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_COPY: begin
                // Vblank edges here are ignored: no restart, no queueing.
                if (r_idx == c_LAST) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_idx_nxt = r_idx + c_ONE;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign cpu_dout = r_cpu_dout;
    assign smd      = r_smd;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire
